// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N-channel button conditioner: sync, debounce, edge, long-press, auto-repeat
module btn_debounce_multi #(
    parameter int N_CH       = 5,
    parameter int CLK_DIV    = 100000,
    parameter int STABLE_CNT = 8,
    parameter int LONG_CNT   = 1000,
    parameter int REPEAT_CNT = 200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_repeat
);

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int DB_W     = $clog2(STABLE_CNT + 1);
    localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(STABLE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CNT);
    localparam logic [HOLD_W-1:0] HOLD_REP  = HOLD_W'(REPEAT_CNT);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;

    logic [N_CH-1:0]   s1_q, s2_q;
    logic [N_CH-1:0]   state_q, state_d;
    logic [N_CH-1:0]   long_q, long_d;
    logic [N_CH-1:0]   rise_q, rise_d;
    logic [N_CH-1:0]   fall_q, fall_d;
    logic [N_CH-1:0]   lpulse_q, lpulse_d;
    logic [N_CH-1:0]   rpulse_q, rpulse_d;
    logic [DB_W-1:0]   db_cnt_q [N_CH];
    logic [DB_W-1:0]   db_cnt_d [N_CH];
    logic [HOLD_W-1:0] hold_q   [N_CH];
    logic [HOLD_W-1:0] hold_d   [N_CH];

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        logic [HOLD_W-1:0] hold_nx;
        hold_nx  = '0;
        state_d  = state_q;
        long_d   = long_q;
        rise_d   = '0;
        fall_d   = '0;
        lpulse_d = '0;
        rpulse_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            db_cnt_d[c] = db_cnt_q[c];
            hold_d[c]   = hold_q[c];
            hold_nx     = hold_q[c] + 1'b1;
            if (tick) begin
                // any tick agreeing with the current state restarts the count
                if (s2_q[c] == state_q[c]) begin
                    db_cnt_d[c] = '0;
                end else if (db_cnt_q[c] == DB_LAST) begin
                    state_d[c]  = s2_q[c];
                    db_cnt_d[c] = '0;
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + 1'b1;
                end

                if (state_d[c] != state_q[c]) begin
                    rise_d[c] = state_d[c];
                    fall_d[c] = ~state_d[c];
                    hold_d[c] = '0;
                    long_d[c] = 1'b0;
                end else if (state_q[c]) begin
                    if (!long_q[c]) begin
                        if (hold_nx == HOLD_LONG) begin
                            lpulse_d[c] = 1'b1;
                            long_d[c]   = 1'b1;
                            hold_d[c]   = '0;
                        end else begin
                            hold_d[c] = hold_nx;
                        end
                    end else if (REPEAT_CNT != 0) begin
                        if (hold_nx == HOLD_REP) begin
                            rpulse_d[c] = 1'b1;
                            hold_d[c]   = '0;
                        end else begin
                            hold_d[c] = hold_nx;
                        end
                    end
                    // with repeat disabled the counter is frozen after the long press
                end else begin
                    hold_d[c] = '0;
                    long_d[c] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            state_q  <= '0;
            long_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            lpulse_q <= '0;
            rpulse_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                db_cnt_q[c] <= '0;
                hold_q[c]   <= '0;
            end
        end else begin
            div_q    <= div_d;
            s1_q     <= btn_in;
            s2_q     <= s1_q;
            state_q  <= state_d;
            long_q   <= long_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            lpulse_q <= lpulse_d;
            rpulse_q <= rpulse_d;
            for (int c = 0; c < N_CH; c++) begin
                db_cnt_q[c] <= db_cnt_d[c];
                hold_q[c]   <= hold_d[c];
            end
        end
    end

    assign btn_level  = state_q;
    assign btn_rise   = rise_q;
    assign btn_fall   = fall_q;
    assign btn_long   = lpulse_q;
    assign btn_repeat = rpulse_q;

endmodule
